// File: rtl/wieg_sturing_if.sv
// Purpose: groups the rocking-controller inputs and outputs into one bundle.
// Latency: none, wiring only.
// Backpressure: none, all signals are plain levels or pulses.
interface wieg_sturing_if;
    logic       start;
    logic       stressLaag;
    logic [7:0] huilVolume;
    logic [7:0] drempel;
    logic       motorAan;
    logic [2:0] snelheid;
    logic [1:0] patroon;
    logic       klaar;
    logic       alarm;

    // Stimulus side: drives the session request and sensor values.
    modport master (
        output start, stressLaag, huilVolume, drempel,
        input  motorAan, snelheid, patroon, klaar, alarm
    );

    // Controller side.
    modport slave (
        input  start, stressLaag, huilVolume, drempel,
        output motorAan, snelheid, patroon, klaar, alarm
    );
endinterface

// File: rtl/wieg_sturing.sv
// Purpose: cradle rocking controller; escalates speed/pattern until the baby calms, then winds down.
// Latency: every output is registered, so it changes on the clock edge after the deciding cycle.
// Backpressure: none; start=0 aborts the session at the next edge.
module wieg_sturing #(
    parameter int EVAL_CYCLES = 16,
    parameter int MAX_NIVEAU  = 7
) (
    input  logic         clk,
    input  logic         r,
    wieg_sturing_if.slave bus
);
    localparam int CW = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
    localparam int DW = CW + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(EVAL_CYCLES - 1);
    localparam logic [DW-1:0] DAAL_HALF = DW'(EVAL_CYCLES / 2);
    localparam logic [2:0]    NIV_MAX   = 3'(MAX_NIVEAU);

    typedef enum logic [2:0] {IDLE, WIEGEN, AFBOUW, RUST, ALARM} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] daal_q, daal_d;
    logic          calm_q, calm_d;
    logic          motor_q, motor_d;
    logic [2:0]    snel_q, snel_d;
    logic [1:0]    pat_q, pat_d;
    logic          klaar_q, klaar_d;
    logic          alarm_q, alarm_d;

    // Samples of the current cycle, folded in so a window end sees its own last cycle.
    logic          is_calm;
    logic          last;
    logic [DW-1:0] daal_sum;
    logic          calm_win;

    assign is_calm  = bus.huilVolume < bus.drempel;
    assign last     = (cnt_q == CNT_LAST);
    assign daal_sum = daal_q + DW'(bus.stressLaag);
    assign calm_win = calm_q & is_calm;

    // Next-state and next-output decision; abort by start=0 always takes priority.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        daal_d  = daal_q;
        calm_d  = calm_q;
        motor_d = motor_q;
        snel_d  = snel_q;
        pat_d   = pat_q;
        klaar_d = 1'b0;
        alarm_d = alarm_q;

        case (state_q)
            IDLE: begin
                motor_d = 1'b0;
                snel_d  = 3'd0;
                pat_d   = 2'd0;
                alarm_d = 1'b0;
                if (bus.start) begin
                    state_d = WIEGEN;
                    motor_d = 1'b1;
                    snel_d  = 3'd1;
                    cnt_d   = '0;
                    daal_d  = '0;
                    calm_d  = 1'b1;
                end
            end
            WIEGEN: begin
                if (!bus.start) begin
                    state_d = IDLE;
                    motor_d = 1'b0;
                    snel_d  = 3'd0;
                    pat_d   = 2'd0;
                    cnt_d   = '0;
                    daal_d  = '0;
                    calm_d  = 1'b1;
                end else if (last) begin
                    cnt_d  = '0;
                    daal_d = '0;
                    calm_d = 1'b1;
                    if (calm_win) begin
                        state_d = AFBOUW;
                    end else if (daal_sum >= DAAL_HALF) begin
                        // stress is falling: hold level and pattern
                    end else if (snel_q < NIV_MAX) begin
                        snel_d = snel_q + 3'd1;
                    end else if (pat_q == 2'd3) begin
                        state_d = ALARM;
                        motor_d = 1'b0;
                        snel_d  = 3'd0;
                        alarm_d = 1'b1;
                    end else begin
                        pat_d  = pat_q + 2'd1;
                        snel_d = 3'd1;
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    daal_d = daal_sum;
                    calm_d = calm_win;
                end
            end
            AFBOUW: begin
                if (!bus.start) begin
                    state_d = IDLE;
                    motor_d = 1'b0;
                    snel_d  = 3'd0;
                    pat_d   = 2'd0;
                    cnt_d   = '0;
                    daal_d  = '0;
                    calm_d  = 1'b1;
                end else if (!is_calm) begin
                    // crying again: resume rocking at the current level with a fresh window
                    state_d = WIEGEN;
                    cnt_d   = '0;
                    daal_d  = '0;
                    calm_d  = 1'b1;
                end else if (last) begin
                    cnt_d  = '0;
                    daal_d = '0;
                    calm_d = 1'b1;
                    if (snel_q <= 3'd1) begin
                        state_d = RUST;
                        motor_d = 1'b0;
                        snel_d  = 3'd0;
                        klaar_d = 1'b1;
                    end else begin
                        snel_d = snel_q - 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUST: begin
                motor_d = 1'b0;
                snel_d  = 3'd0;
                if (!bus.start) begin
                    state_d = IDLE;
                    pat_d   = 2'd0;
                end
            end
            ALARM: begin
                motor_d = 1'b0;
                snel_d  = 3'd0;
                if (!bus.start) begin
                    state_d = IDLE;
                    pat_d   = 2'd0;
                    alarm_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                motor_d = 1'b0;
                snel_d  = 3'd0;
                pat_d   = 2'd0;
                alarm_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            daal_q  <= '0;
            calm_q  <= 1'b0;
            motor_q <= 1'b0;
            snel_q  <= 3'd0;
            pat_q   <= 2'd0;
            klaar_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            daal_q  <= daal_d;
            calm_q  <= calm_d;
            motor_q <= motor_d;
            snel_q  <= snel_d;
            pat_q   <= pat_d;
            klaar_q <= klaar_d;
            alarm_q <= alarm_d;
        end
    end

    assign bus.motorAan = motor_q;
    assign bus.snelheid = snel_q;
    assign bus.patroon  = pat_q;
    assign bus.klaar    = klaar_q;
    assign bus.alarm    = alarm_q;
endmodule

// File: tb/tb_wieg_sturing.sv
// Purpose: directed bench for the rocking controller with EVAL_CYCLES=4, MAX_NIVEAU=3, drempel=40.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_wieg_sturing;
    logic clk;
    logic r;
    int   total;
    int   bad;

    wieg_sturing_if bus ();

    wieg_sturing #(.EVAL_CYCLES(4), .MAX_NIVEAU(3)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        r     = 1'b0;
        bus.start      = 1'b0;
        bus.stressLaag = 1'b0;
        bus.huilVolume = 8'd0;
        bus.drempel    = 8'd40;

        // reset state
        #3;
        check("rst_motor", 32'(bus.motorAan), 32'd0);
        check("rst_snel",  32'(bus.snelheid), 32'd0);
        check("rst_pat",   32'(bus.patroon),  32'd0);
        check("rst_klaar", 32'(bus.klaar),    32'd0);
        check("rst_alarm", 32'(bus.alarm),    32'd0);
        #9 r = 1'b1;
        tick(1);
        check("idle_motor", 32'(bus.motorAan), 32'd0);

        // full escalation without improvement ends in alarm
        bus.start = 1'b1;
        bus.huilVolume = 8'd200;
        tick(1);
        check("esc_entry_motor", 32'(bus.motorAan), 32'd1);
        check("esc_entry_snel",  32'(bus.snelheid), 32'd1);
        check("esc_entry_pat",   32'(bus.patroon),  32'd0);
        tick(3);
        check("esc_mid_snel", 32'(bus.snelheid), 32'd1);
        tick(1);
        check("esc_snel2", 32'(bus.snelheid), 32'd2);
        tick(4);
        check("esc_snel3", 32'(bus.snelheid), 32'd3);
        tick(4);
        check("esc_pat1", 32'(bus.patroon),  32'd1);
        check("esc_pat1_snel", 32'(bus.snelheid), 32'd1);
        tick(32);
        check("esc_pat3", 32'(bus.patroon),  32'd3);
        check("esc_pat3_snel", 32'(bus.snelheid), 32'd3);
        tick(3);
        check("esc_prealarm", 32'(bus.alarm), 32'd0);
        check("esc_prealarm_motor", 32'(bus.motorAan), 32'd1);
        tick(1);
        check("esc_alarm",       32'(bus.alarm),    32'd1);
        check("esc_alarm_motor", 32'(bus.motorAan), 32'd0);
        check("esc_alarm_snel",  32'(bus.snelheid), 32'd0);
        check("esc_alarm_pat",   32'(bus.patroon),  32'd3);
        tick(2);
        check("esc_alarm_hold", 32'(bus.alarm), 32'd1);
        bus.start = 1'b0;
        tick(1);
        check("alarm_clear", 32'(bus.alarm),   32'd0);
        check("alarm_pat0",  32'(bus.patroon), 32'd0);

        // stress falling on half the cycles holds the level
        bus.start = 1'b1;
        tick(1);
        for (int w = 0; w < 3; w++) begin
            bus.stressLaag = 1'b1; tick(1);
            bus.stressLaag = 1'b1; tick(1);
            bus.stressLaag = 1'b0; tick(2);
            check("stay_snel", 32'(bus.snelheid), 32'd1);
            check("stay_pat",  32'(bus.patroon),  32'd0);
        end
        bus.stressLaag = 1'b1; tick(1);
        bus.stressLaag = 1'b0; tick(3);
        check("one_of_four_snel", 32'(bus.snelheid), 32'd2);
        bus.stressLaag = 1'b0; tick(2);
        bus.stressLaag = 1'b1; tick(2);
        bus.stressLaag = 1'b0;
        check("late_stress_stay", 32'(bus.snelheid), 32'd2);
        bus.start = 1'b0;
        tick(1);
        check("stop_motor", 32'(bus.motorAan), 32'd0);
        check("stop_snel",  32'(bus.snelheid), 32'd0);

        // calm baby: wind down to rest with one klaar pulse
        bus.start = 1'b1;
        bus.huilVolume = 8'd200;
        tick(1);
        tick(8);
        check("wd_snel3", 32'(bus.snelheid), 32'd3);
        bus.huilVolume = 8'd10;
        tick(4);
        check("wd_afbouw_snel",  32'(bus.snelheid), 32'd3);
        check("wd_afbouw_motor", 32'(bus.motorAan), 32'd1);
        check("wd_afbouw_pat",   32'(bus.patroon),  32'd0);
        tick(4);
        check("wd_snel2", 32'(bus.snelheid), 32'd2);
        tick(4);
        check("wd_snel1", 32'(bus.snelheid), 32'd1);
        tick(3);
        check("wd_noklaar", 32'(bus.klaar),    32'd0);
        check("wd_snel1b",  32'(bus.snelheid), 32'd1);
        tick(1);
        check("wd_klaar",       32'(bus.klaar),    32'd1);
        check("wd_rust_snel",   32'(bus.snelheid), 32'd0);
        check("wd_rust_motor",  32'(bus.motorAan), 32'd0);
        tick(1);
        check("wd_klaar_once", 32'(bus.klaar), 32'd0);
        tick(4);
        check("wd_rust_norestart", 32'(bus.motorAan), 32'd0);
        bus.start = 1'b0;
        tick(1);

        // renewed crying during wind-down resumes rocking at the current level
        bus.start = 1'b1;
        bus.huilVolume = 8'd200;
        tick(1);
        tick(8);
        bus.huilVolume = 8'd10;
        tick(4);
        tick(4);
        check("re_afbouw_snel2", 32'(bus.snelheid), 32'd2);
        bus.huilVolume = 8'd100;
        tick(1);
        check("re_wiegen_snel",  32'(bus.snelheid), 32'd2);
        check("re_wiegen_motor", 32'(bus.motorAan), 32'd1);
        bus.huilVolume = 8'd200;
        tick(3);
        check("re_window_mid", 32'(bus.snelheid), 32'd2);
        tick(1);
        check("re_window_end", 32'(bus.snelheid), 32'd3);
        bus.start = 1'b0;
        tick(1);

        // start falling on a window-end cycle wins over the level change
        bus.start = 1'b1;
        tick(1);
        tick(3);
        bus.start = 1'b0;
        tick(1);
        check("abort_snel",  32'(bus.snelheid), 32'd0);
        check("abort_motor", 32'(bus.motorAan), 32'd0);
        check("abort_klaar", 32'(bus.klaar),    32'd0);
        tick(1);
        check("abort_idle", 32'(bus.snelheid), 32'd0);

        // volume equal to the threshold is not calm; one below is
        bus.start = 1'b1;
        bus.huilVolume = 8'd40;
        tick(1);
        tick(4);
        check("thr_equal_escalates", 32'(bus.snelheid), 32'd2);
        bus.huilVolume = 8'd39;
        tick(4);
        tick(3);
        check("thr_below_afbouw", 32'(bus.snelheid), 32'd2);
        tick(1);
        check("thr_below_decr", 32'(bus.snelheid), 32'd1);
        bus.start = 1'b0;
        tick(1);

        // asynchronous reset mid-window
        bus.start = 1'b1;
        bus.huilVolume = 8'd200;
        tick(1);
        tick(2);
        #2 r = 1'b0;
        #1;
        check("arst_motor", 32'(bus.motorAan), 32'd0);
        check("arst_snel",  32'(bus.snelheid), 32'd0);
        check("arst_klaar", 32'(bus.klaar),    32'd0);
        bus.start = 1'b0;
        #3 r = 1'b1;
        tick(3);
        check("arst_quiet", 32'(bus.motorAan), 32'd0);
        bus.start = 1'b1;
        tick(1);
        check("arst_restart_motor", 32'(bus.motorAan), 32'd1);
        check("arst_restart_snel",  32'(bus.snelheid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
